// File: rtl/speaker_i2s_tx.sv
// I2S transmitter for the stereo DAC PMOD: one free-running counter supplies
// MCLK/SCK/LRCK, and a frame-captured shift register drives SDIN with the I2S 1-bit delay.
module speaker_i2s_tx #(
    parameter int MCLK_LOG2 = 2,
    parameter int SCK_LOG2  = 5,
    parameter int SAMPLE_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    input  logic                mute,
    output logic                audio_mclk,
    output logic                audio_lrck,
    output logic                audio_sck,
    output logic                audio_sdin,
    output logic                frame_tick
);

    localparam int FW = 2 * SAMPLE_W;
    localparam int CW = SCK_LOG2 + $clog2(FW);
    localparam logic [CW-1:0] TICK_PRE = {{(CW-1){1'b1}}, 1'b0};

    logic [CW-1:0] cnt;
    logic [FW-1:0] sr;
    logic          bit_edge;
    logic          frame_edge;

    // SCK falls on the edge where the low counter bits are all ones
    assign bit_edge   = &cnt[SCK_LOG2-1:0];
    assign frame_edge = &cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sr         <= '0;
            audio_sdin <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt + CW'(1);
            // Registered one cycle early so the tick is high while cnt is all ones
            frame_tick <= (cnt == TICK_PRE);
            if (bit_edge) begin
                audio_sdin <= sr[FW-1];
                if (frame_edge) begin
                    sr <= mute ? '0 : {audio_left, audio_right};
                end else begin
                    sr <= {sr[FW-2:0], 1'b0};
                end
            end
        end
    end

    assign audio_mclk = cnt[MCLK_LOG2-1];
    assign audio_sck  = cnt[SCK_LOG2-1];
    assign audio_lrck = cnt[CW-1];

endmodule

// File: tb/tb_speaker_i2s_tx.sv
// Bench for speaker_i2s_tx: per-cycle reference model of all pins plus
// table-driven frame decoding and hand-written reset/boundary sequences.
module tb_speaker_i2s_tx;

    localparam int MCLK_LOG2 = 2;
    localparam int SCK_LOG2  = 5;
    localparam int SAMPLE_W  = 16;
    localparam int SLOT      = 1 << SCK_LOG2;
    localparam int FRAME     = SLOT * 2 * SAMPLE_W;
    localparam int NFR       = 64;
    localparam int NV        = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] audio_left = '0;
    logic [15:0] audio_right = '0;
    logic mute = 1'b0;
    logic audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_tick;

    speaker_i2s_tx #(.MCLK_LOG2(MCLK_LOG2), .SCK_LOG2(SCK_LOG2), .SAMPLE_W(SAMPLE_W)) dut (
        .clk(clk), .rst(rst), .audio_left(audio_left), .audio_right(audio_right),
        .mute(mute), .audio_mclk(audio_mclk), .audio_lrck(audio_lrck),
        .audio_sck(audio_sck), .audio_sdin(audio_sdin), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: clk count since reset and the 32-bit word sent in each frame
    int t = 0;
    logic [31:0] frames [NFR];

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            for (int i = 0; i < NFR; i++) frames[i] = '0;
        end else begin
            if (t % FRAME == FRAME - 1 && t / FRAME + 1 < NFR)
                frames[t / FRAME + 1] = mute ? 32'h0 : {audio_left, audio_right};
            t++;
        end
    end

    function automatic logic exp_sdin(input int tt);
        int c, f, s;
        c = tt % FRAME;
        f = tt / FRAME;
        s = c / SLOT;
        if (f >= NFR) return 1'b0;
        if (s == 0) return (f == 0) ? 1'b0 : frames[f-1][0];
        return frames[f][32 - s];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int c;
            logic [4:0] exp_pins;
            c = t % FRAME;
            exp_pins[4] = ((c / (1 << (MCLK_LOG2 - 1))) % 2) == 1;
            exp_pins[3] = c >= FRAME / 2;
            exp_pins[2] = ((c / (SLOT / 2)) % 2) == 1;
            exp_pins[1] = exp_sdin(t);
            exp_pins[0] = (c == FRAME - 1);
            check("pins{mclk,lrck,sck,sdin,tick}",
                  {27'h0, audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_tick},
                  {27'h0, exp_pins});
        end
    end

    // Advance at least one negedge, then stop where the model count reaches cnt value c
    task automatic wait_c(input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (t % FRAME != c && n < 2 * FRAME);
        if (n >= 2 * FRAME) check("wait_c_timeout", n, 0);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 2 * FRAME);
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        m;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        int n;
        logic [31:0] w;

        vecs[0] = '{16'hA5C3, 16'h3C0F, 1'b0, 16'hA5C3, 16'h3C0F};
        vecs[1] = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 16'h0000};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h8000, 16'h0001};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFF};
        vecs[6] = '{16'h7FFF, 16'h8000, 1'b0, 16'h7FFF, 16'h8000};
        vecs[7] = '{16'h5555, 16'hAAAA, 1'b0, 16'h5555, 16'hAAAA};
        for (int i = 8; i < NV; i++) begin
            vecs[i].l  = 16'($urandom);
            vecs[i].r  = 16'($urandom);
            vecs[i].m  = (i == 9) ? 1'b1 : 1'b0;
            vecs[i].el = vecs[i].m ? 16'h0 : vecs[i].l;
            vecs[i].er = vecs[i].m ? 16'h0 : vecs[i].r;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_outputs", {27'h0, audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_tick}, 32'h0);
        rst = 1'b0;
        wait_tick(n);
        check("first_tick_delay", n, FRAME - 1);

        // First table entry is loaded ahead of the decode loop
        wait_c(600);
        audio_left  = vecs[0].l;
        audio_right = vecs[0].r;
        wait_c(FRAME - 1);
        mute = vecs[0].m;
        wait_c(0);
        mute = 1'b0;

        for (int i = 0; i < NV; i++) begin
            w = '0;
            for (int s = 1; s <= 32; s++) begin
                if (s == 19 && i < NV - 1) begin
                    wait_c(600);
                    audio_left  = vecs[i+1].l;
                    audio_right = vecs[i+1].r;
                end
                if (s == 32) begin
                    wait_c(FRAME - 1);
                    mute = (i < NV - 1) ? vecs[i+1].m : 1'b0;
                    wait_c(0);
                    mute = 1'b0;
                end
                wait_c((s * SLOT + SLOT / 2) % FRAME);
                w = {w[30:0], audio_sdin};
                if (i == 3 && s == 1) check("after_r0_carry", {31'h0, audio_sdin}, 32'h0);
            end
            if (i == 2) check("r0_carry_slot0", {31'h0, audio_sdin}, 32'h1);
            check($sformatf("vec%0d_left", i), {16'h0, w[31:16]}, {16'h0, vecs[i].el});
            check($sformatf("vec%0d_right", i), {16'h0, w[15:0]}, {16'h0, vecs[i].er});
        end

        // Mid-word reset
        audio_left  = 16'hFFFF;
        audio_right = 16'hFFFF;
        wait_c(700);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {27'h0, audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_tick}, 32'h0);
        rst = 1'b0;
        wait_tick(n);
        check("midreset_tick_delay", n, FRAME - 1);
        repeat (80) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
